// File: rtl/snn_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : snn_phase_sequencer
// Purpose  : Time-unit sequencer for the SNN datapath. Walks through
//            NUM_PHASES processing phases, issuing a one-cycle one-hot start
//            pulse per phase and waiting for that phase's done bit. After the
//            last phase it advances the time-unit (TU) counter. Supports a TU
//            limit, free-running / single-step operation, a per-phase
//            watchdog, abort and clear.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1           clock, rising edge
//   rst_n          in   1           synchronous active-low reset
//   go             in   1           start a TU when idle (level)
//   auto_run       in   1           1: chain next TU after END, 0: go idle
//   tu_limit       in   TU_W        halt when tu equals this (0 = unlimited)
//   timeout_cycles in   TO_W        per-phase watchdog limit (0 = disabled)
//   abort          in   1           return to IDLE, tu and flags kept
//   clear          in   1           return to IDLE, tu and flags zeroed
//   phase_done     in   NUM_PHASES  per-phase completion (active bit only)
//   phase_start    out  NUM_PHASES  one-hot one-cycle start pulse
//   phase          out  PH_W        active phase index
//   tu             out  TU_W        time-unit count
//   tu_incre       out  1           tu just advanced (END cycle)
//   busy           out  1           sequencing in progress
//   halted         out  1           tu_limit reached
//   timeout_err    out  1           sticky watchdog error
//   err_phase      out  PH_W        phase that timed out
// ============================================================================
module snn_phase_sequencer #(
    parameter int NUM_PHASES = 5,
    parameter int TU_W       = 16,
    parameter int TO_W       = 12,
    localparam int PH_W      = ($clog2(NUM_PHASES) > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic                  auto_run,
    input  logic [TU_W-1:0]       tu_limit,
    input  logic [TO_W-1:0]       timeout_cycles,
    input  logic                  abort,
    input  logic                  clear,
    input  logic [NUM_PHASES-1:0] phase_done,
    output logic [NUM_PHASES-1:0] phase_start,
    output logic [PH_W-1:0]       phase,
    output logic [TU_W-1:0]       tu,
    output logic                  tu_incre,
    output logic                  busy,
    output logic                  halted,
    output logic                  timeout_err,
    output logic [PH_W-1:0]       err_phase
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_END   = 3'd3,
        S_HALT  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [PH_W-1:0]       LAST_PHASE = PH_W'(NUM_PHASES - 1);
    localparam logic [NUM_PHASES-1:0] ONE_HOT0   = NUM_PHASES'(1);

    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [TU_W-1:0] tu_q, tu_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            terr_q, terr_d;
    logic [PH_W-1:0] ephase_q, ephase_d;

    logic done_active;
    logic wd_expire;

    // Only the active phase's done bit matters; the rest are ignored.
    assign done_active = phase_done[phase_q];

    // The watchdog counter holds k-1 during the k-th WAIT cycle, so matching
    // limit-1 means this is the limit-th WAIT cycle without a done.
    assign wd_expire = (timeout_cycles != '0) &&
                       (wd_q == (timeout_cycles - TO_W'(1)));

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        tu_d     = tu_q;
        wd_d     = wd_q;
        terr_d   = terr_q;
        ephase_d = ephase_q;

        if (clear) begin
            state_d  = S_IDLE;
            phase_d  = '0;
            tu_d     = '0;
            wd_d     = '0;
            terr_d   = 1'b0;
            ephase_d = '0;
        end else if (abort) begin
            state_d = S_IDLE;
            phase_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        phase_d = '0;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    wd_d    = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving in the expiry cycle still counts.
                    if (done_active) begin
                        if (phase_q == LAST_PHASE) begin
                            tu_d    = tu_q + TU_W'(1);
                            state_d = S_END;
                        end else begin
                            phase_d = phase_q + PH_W'(1);
                            state_d = S_START;
                        end
                    end else if (wd_expire) begin
                        terr_d   = 1'b1;
                        ephase_d = phase_q;
                        state_d  = S_ERR;
                    end else begin
                        wd_d = wd_q + TO_W'(1);
                    end
                end
                S_END: begin
                    // tu_q already holds the advanced count here.
                    if ((tu_limit != '0) && (tu_q == tu_limit)) begin
                        state_d = S_HALT;
                    end else if (auto_run) begin
                        phase_d = '0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HALT,
                S_ERR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            tu_q     <= '0;
            wd_q     <= '0;
            terr_q   <= 1'b0;
            ephase_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            tu_q     <= tu_d;
            wd_q     <= wd_d;
            terr_q   <= terr_d;
            ephase_q <= ephase_d;
        end
    end

    // All outputs decode from registered state only.
    assign phase_start = (state_q == S_START) ? (ONE_HOT0 << phase_q) : '0;
    assign phase       = phase_q;
    assign tu          = tu_q;
    assign tu_incre    = (state_q == S_END);
    assign busy        = (state_q == S_START) || (state_q == S_WAIT) ||
                         (state_q == S_END);
    assign halted      = (state_q == S_HALT);
    assign timeout_err = terr_q;
    assign err_phase   = ephase_q;

endmodule
`default_nettype wire

// File: tb/tb_snn_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_phase_sequencer
// Purpose  : Self-checking bench for snn_phase_sequencer (TU_W=4 build so the
//            time-unit wrap is reachable quickly).
// Revision : 1.0 - initial release
// ============================================================================
module tb_snn_phase_sequencer;

    localparam int NP   = 5;
    localparam int TU_W = 4;
    localparam int TO_W = 12;
    localparam int PH_W = 3;
    localparam int TU_MOD = 1 << TU_W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            go = 1'b0;
    logic            auto_run = 1'b0;
    logic            abort = 1'b0;
    logic            clear = 1'b0;
    logic [TU_W-1:0] tu_limit = '0;
    logic [TO_W-1:0] timeout_cycles = '0;
    logic [NP-1:0]   phase_done = '0;

    logic [NP-1:0]   phase_start;
    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] err_phase;
    logic [TU_W-1:0] tu;
    logic            tu_incre;
    logic            busy;
    logic            halted;
    logic            timeout_err;

    int nvec = 0;
    int nerr = 0;
    int model_tu = 0;
    bit model_terr = 1'b0;

    snn_phase_sequencer #(
        .NUM_PHASES (NP),
        .TU_W       (TU_W),
        .TO_W       (TO_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .go             (go),
        .auto_run       (auto_run),
        .tu_limit       (tu_limit),
        .timeout_cycles (timeout_cycles),
        .abort          (abort),
        .clear          (clear),
        .phase_done     (phase_done),
        .phase_start    (phase_start),
        .phase          (phase),
        .tu             (tu),
        .tu_incre       (tu_incre),
        .busy           (busy),
        .halted         (halted),
        .timeout_err    (timeout_err),
        .err_phase      (err_phase)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_tu   = 0;
        model_terr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        nvec++; if (phase_start !== '0) begin nerr++; $display("FAIL reset_phase_start got %b exp 0", phase_start); end
        nvec++; if (phase !== '0) begin nerr++; $display("FAIL reset_phase got %0d exp 0", phase); end
        nvec++; if (tu !== '0) begin nerr++; $display("FAIL reset_tu got %0d exp 0", tu); end
        nvec++; if (tu_incre !== 1'b0) begin nerr++; $display("FAIL reset_tu_incre got %b exp 0", tu_incre); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b exp 0", busy); end
        nvec++; if (halted !== 1'b0) begin nerr++; $display("FAIL reset_halted got %b exp 0", halted); end
        nvec++; if (timeout_err !== 1'b0) begin nerr++; $display("FAIL reset_timeout_err got %b exp 0", timeout_err); end
        nvec++; if (err_phase !== '0) begin nerr++; $display("FAIL reset_err_phase got %0d exp 0", err_phase); end
    endtask

    // One TU, each done returned the cycle after its start: 11 cycles total.
    task automatic test_basic();
        logic [NP-1:0] exp;
        int cyc;
        auto_run = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        cyc = 1;
        for (int p = 0; p < NP; p++) begin
            exp = '0;
            exp[p] = 1'b1;
            nvec++; if (phase_start !== exp) begin nerr++; $display("FAIL basic_start[%0d] got %b exp %b", p, phase_start, exp); end
            nvec++; if (phase !== PH_W'(p)) begin nerr++; $display("FAIL basic_phase got %0d exp %0d", phase, p); end
            tick(); cyc++;
            phase_done = exp;
            nvec++; if (phase_start !== '0 || busy !== 1'b1) begin nerr++; $display("FAIL basic_wait start=%b busy=%b exp 0/1", phase_start, busy); end
            tick(); cyc++;
            phase_done = '0;
        end
        model_tu = 1;
        nvec++; if (tu_incre !== 1'b1) begin nerr++; $display("FAIL basic_tu_incre got %b exp 1", tu_incre); end
        nvec++; if (tu !== TU_W'(model_tu)) begin nerr++; $display("FAIL basic_tu got %0d exp %0d", tu, model_tu); end
        nvec++; if (cyc !== 11) begin nerr++; $display("FAIL basic_cycles got %0d exp 11", cyc); end
        tick();
        nvec++; if (busy !== 1'b0 || tu_incre !== 1'b0) begin nerr++; $display("FAIL basic_idle busy=%b incre=%b exp 0/0", busy, tu_incre); end
    endtask

    task automatic test_limit();
        int pulses = 0;
        int halt_cyc = 0;
        int late = 0;
        pulse_clear();
        auto_run = 1'b1;
        tu_limit = TU_W'(3);
        phase_done = '1;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (tu_incre === 1'b1) pulses++;
            if (halted === 1'b1 && halt_cyc == 0) halt_cyc = c;
            if (halt_cyc != 0 && phase_start !== '0) late++;
            tick();
        end
        nvec++; if (pulses !== 3) begin nerr++; $display("FAIL limit_pulses got %0d exp 3", pulses); end
        nvec++; if (halt_cyc !== 34) begin nerr++; $display("FAIL limit_halt_cycle got %0d exp 34", halt_cyc); end
        nvec++; if (late !== 0) begin nerr++; $display("FAIL limit_late_starts got %0d exp 0", late); end
        nvec++; if (tu !== TU_W'(3) || halted !== 1'b1 || busy !== 1'b0) begin nerr++; $display("FAIL limit_final tu=%0d halted=%b busy=%b exp 3/1/0", tu, halted, busy); end
        pulse_clear();
        nvec++; if (tu !== '0 || halted !== 1'b0) begin nerr++; $display("FAIL limit_clear tu=%0d halted=%b exp 0/0", tu, halted); end
        auto_run = 1'b0;
        tu_limit = '0;
        phase_done = '0;
    endtask

    task automatic test_timeout();
        timeout_cycles = TO_W'(4);
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            phase_done = (c <= 4) ? 5'b00011 : 5'b00000;
            if (c == 9) begin
                nvec++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL to_pre terr=%b busy=%b exp 0/1", timeout_err, busy); end
            end
            tick();
        end
        phase_done = '0;
        nvec++; if (timeout_err !== 1'b1 || err_phase !== PH_W'(2)) begin nerr++; $display("FAIL to_err terr=%b ephase=%0d exp 1/2", timeout_err, err_phase); end
        nvec++; if (busy !== 1'b0 || phase_start !== '0) begin nerr++; $display("FAIL to_err_state busy=%b start=%b exp 0/0", busy, phase_start); end
        go = 1'b1;
        tick(); tick();
        go = 1'b0;
        nvec++; if (busy !== 1'b0 || phase_start !== '0) begin nerr++; $display("FAIL to_hold busy=%b start=%b exp 0/0", busy, phase_start); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        nvec++; if (timeout_err !== 1'b1 || tu !== TU_W'(model_tu)) begin nerr++; $display("FAIL to_abort_sticky terr=%b tu=%0d exp 1/%0d", timeout_err, tu, model_tu); end
        pulse_clear();
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            phase_done = (c <= 4) ? 5'b00011 : ((c == 9) ? 5'b00100 : 5'b00000);
            tick();
        end
        phase_done = '0;
        nvec++; if (timeout_err !== 1'b0 || phase_start !== 5'b01000) begin nerr++; $display("FAIL to_done_wins terr=%b start=%b exp 0/01000", timeout_err, phase_start); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        timeout_cycles = '0;
    endtask

    task automatic test_wrap();
        int pulses = 0;
        pulse_clear();
        auto_run = 1'b1;
        tu_limit = '0;
        phase_done = '1;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int c = 0; c < 250 && pulses < TU_MOD; c++) begin
            if (tu_incre === 1'b1) begin
                pulses++;
                nvec++; if (tu !== TU_W'(pulses % TU_MOD)) begin nerr++; $display("FAIL wrap_tu got %0d exp %0d", tu, pulses % TU_MOD); end
            end
            if (pulses < TU_MOD) tick();
        end
        nvec++; if (pulses !== TU_MOD) begin nerr++; $display("FAIL wrap_pulses got %0d exp %0d", pulses, TU_MOD); end
        auto_run = 1'b0;
        tick();
        phase_done = '0;
        model_tu = 0;
        nvec++; if (busy !== 1'b0 || tu !== '0 || halted !== 1'b0) begin nerr++; $display("FAIL wrap_final busy=%b tu=%0d halted=%b exp 0/0/0", busy, tu, halted); end
    endtask

    task automatic test_abort();
        pulse_clear();
        tu_limit = TU_W'(5);
        auto_run = 1'b1;
        phase_done = '1;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int c = 0; c < 80 && halted !== 1'b1; c++) tick();
        nvec++; if (halted !== 1'b1 || tu !== TU_W'(5)) begin nerr++; $display("FAIL abort_setup halted=%b tu=%0d exp 1/5", halted, tu); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        model_tu = 5;
        nvec++; if (halted !== 1'b0 || busy !== 1'b0 || tu !== TU_W'(5)) begin nerr++; $display("FAIL abort_halt halted=%b busy=%b tu=%0d exp 0/0/5", halted, busy, tu); end
        tu_limit = '0;
        auto_run = 1'b0;
        phase_done = '0;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            phase_done = (c <= 6) ? 5'b00111 : 5'b00000;
            abort = (c == 8);
            if (c == 7) begin
                nvec++; if (phase_start !== 5'b01000) begin nerr++; $display("FAIL abort_p3_start got %b exp 01000", phase_start); end
            end
            tick();
        end
        abort = 1'b0;
        nvec++; if (busy !== 1'b0 || tu !== TU_W'(5) || phase !== '0 || phase_start !== '0) begin nerr++; $display("FAIL abort_wait busy=%b tu=%0d phase=%0d start=%b exp 0/5/0/0", busy, tu, phase, phase_start); end
        tick(); tick();
        nvec++; if (phase_start !== '0) begin nerr++; $display("FAIL abort_no_start got %b exp 0", phase_start); end
        go = 1'b1;
        tick();
        go = 1'b0;
        nvec++; if (phase_start !== 5'b00001 || phase !== '0) begin nerr++; $display("FAIL abort_restart start=%b phase=%0d exp 00001/0", phase_start, phase); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_wrong_phase();
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            phase_done = (c == 2) ? 5'b00001 : ((c >= 4 && c <= 6) ? 5'b10000 : ((c == 7) ? 5'b00010 : 5'b00000));
            if (c == 6) begin
                nvec++; if (phase !== PH_W'(1) || phase_start !== '0 || busy !== 1'b1) begin nerr++; $display("FAIL wrong_ignored phase=%0d start=%b busy=%b exp 1/0/1", phase, phase_start, busy); end
            end
            tick();
        end
        phase_done = '0;
        nvec++; if (phase_start !== 5'b00100) begin nerr++; $display("FAIL wrong_then_right got %b exp 00100", phase_start); end
        clear = 1'b1;
        abort = 1'b1;
        tick();
        clear = 1'b0;
        abort = 1'b0;
        model_tu = 0;
        model_terr = 1'b0;
        nvec++; if (tu !== '0 || busy !== 1'b0 || phase !== '0) begin nerr++; $display("FAIL clear_abort tu=%0d busy=%b phase=%0d exp 0/0/0", tu, busy, phase); end
    endtask

    // Random TUs: the expected timeline is computed up front from per-phase
    // done delays and the watchdog limit, then checked cycle by cycle.
    task automatic test_random(input int iters);
        int d[NP];
        int s[NP];
        int T, nph, errp, endc, t, ap, win;
        bit err;
        logic [NP-1:0] drv;
        logic [NP-1:0] exp_ps;
        bit exp_busy, exp_incre;
        pulse_clear();
        auto_run = 1'b0;
        tu_limit = '0;
        for (int it = 0; it < iters; it++) begin
            T = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(2, 8));
            timeout_cycles = TO_W'(T);
            for (int p = 0; p < NP; p++) d[p] = int'($urandom_range(1, 8));
            err = 1'b0; errp = 0; nph = NP; t = 1; endc = 0;
            for (int p = 0; p < NP; p++) begin
                s[p] = t;
                if (T != 0 && d[p] > T) begin
                    err = 1'b1; errp = p; nph = p + 1; endc = t + T + 1;
                    break;
                end
                t += d[p] + 1;
            end
            if (!err) endc = t;
            go = 1'b1;
            tick();
            for (int c = 1; c <= endc; c++) begin
                ap = -1;
                for (int p = 0; p < nph; p++) begin
                    win = (err && p == errp) ? T : d[p];
                    if (c >= s[p] && c <= s[p] + win) ap = p;
                end
                exp_ps = '0;
                if (ap >= 0 && c == s[ap]) exp_ps[ap] = 1'b1;
                exp_busy  = (ap >= 0) || (!err && c == endc);
                exp_incre = (!err && c == endc);
                nvec++; if (phase_start !== exp_ps) begin nerr++; $display("FAIL rnd_start it=%0d c=%0d got %b exp %b", it, c, phase_start, exp_ps); end
                nvec++; if (busy !== exp_busy || tu_incre !== exp_incre) begin nerr++; $display("FAIL rnd_busy_incre it=%0d c=%0d got %b/%b exp %b/%b", it, c, busy, tu_incre, exp_busy, exp_incre); end
                if (ap >= 0) begin
                    nvec++; if (phase !== PH_W'(ap)) begin nerr++; $display("FAIL rnd_phase it=%0d c=%0d got %0d exp %0d", it, c, phase, ap); end
                end
                drv = NP'($urandom);
                if (ap >= 0 && c != s[ap]) drv[ap] = (!(err && ap == errp) && c == s[ap] + d[ap]);
                phase_done = drv;
                go = 1'($urandom_range(0, 1));
                if (c < endc) tick();
            end
            go = 1'b0;
            if (!err) begin
                model_tu = (model_tu + 1) % TU_MOD;
                nvec++; if (tu !== TU_W'(model_tu) || timeout_err !== model_terr) begin nerr++; $display("FAIL rnd_end it=%0d tu=%0d terr=%b exp %0d/%b", it, tu, timeout_err, model_tu, model_terr); end
                phase_done = '0;
                tick();
                nvec++; if (busy !== 1'b0 || phase_start !== '0) begin nerr++; $display("FAIL rnd_idle it=%0d busy=%b start=%b exp 0/0", it, busy, phase_start); end
            end else begin
                model_terr = 1'b1;
                nvec++; if (timeout_err !== 1'b1 || err_phase !== PH_W'(errp) || tu !== TU_W'(model_tu)) begin nerr++; $display("FAIL rnd_err it=%0d terr=%b ephase=%0d tu=%0d exp 1/%0d/%0d", it, timeout_err, err_phase, tu, errp, model_tu); end
                phase_done = '0;
                if ($urandom_range(0, 1) == 0) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                end else begin
                    pulse_clear();
                end
                nvec++; if (busy !== 1'b0 || timeout_err !== model_terr || tu !== TU_W'(model_tu)) begin nerr++; $display("FAIL rnd_recover it=%0d busy=%b terr=%b tu=%0d exp 0/%b/%0d", it, busy, timeout_err, tu, model_terr, model_tu); end
            end
        end
        timeout_cycles = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_limit();
        test_timeout();
        test_wrap();
        test_abort();
        test_wrong_phase();
        test_random(30);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
